counter_mod_updown: RTL and testbench

//  Parametrised up/down modulo-N counter with parallel load, cascade output and wrap/saturate modes.

---
 rtl/cnt_pkg.sv | 17 +
 rtl/counter_mod_updown_if.sv | 23 ++
 rtl/counter_mod_updown.sv | 75 +++++++
 tb/tb_counter_mod_updown.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/cnt_pkg.sv
// Shared constants and helpers for the up/down modulo-N counter family.
// Imported by the counter RTL.
package cnt_pkg;

  typedef enum logic {
    CNT_MODE_WRAP = 1'b0,
    CNT_MODE_SAT  = 1'b1
  } cnt_mode_e;

  // Limits a load value to the legal count range 0..modulus-1.
  function automatic logic [31:0] cnt_clamp(input logic [32:0] value, input logic [32:0] modulus);
    logic [32:0] top;
    top = modulus - 33'd1;
    return (value < modulus) ? value[31:0] : top[31:0];
  endfunction

endpackage

// File: rtl/counter_mod_updown_if.sv
// Control and status bundle of one counter stage.
// The master drives the controls; the counter is the slave.
interface counter_mod_updown_if #(
  parameter int WIDTH = 4
);
  logic             EN;
  logic             UP;
  logic             LD;
  logic [WIDTH-1:0] D_IN;
  logic [WIDTH-1:0] Q_OUT;
  logic             TC_OUT;
  logic             EVT_OUT;

  modport master (
    output EN, UP, LD, D_IN,
    input  Q_OUT, TC_OUT, EVT_OUT
  );

  modport slave (
    input  EN, UP, LD, D_IN,
    output Q_OUT, TC_OUT, EVT_OUT
  );
endinterface

// File: rtl/counter_mod_updown.sv
// Up/down modulo-N counter with clamped parallel load, wrap or saturate at the limits,
// a combinational terminal count for cascading and a registered limit-hit pulse.
module counter_mod_updown
  import cnt_pkg::*;
#(
  parameter int     WIDTH     = 4,
  parameter longint MODULUS   = 16,
  parameter int     SATURATE  = 0,
  parameter longint RESET_VAL = 0
) (
  input logic                 CLK,
  input logic                 CLR_N,
  counter_mod_updown_if.slave bus
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("counter_mod_updown: WIDTH must be 1..32");
  end
  if (MODULUS < 2 || MODULUS > (longint'(1) << WIDTH)) begin : g_bad_modulus
    $error("counter_mod_updown: MODULUS must be 2..2**WIDTH");
  end
  if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset
    $error("counter_mod_updown: RESET_VAL must be below MODULUS");
  end

  localparam logic [WIDTH:0]   MOD_X   = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_Q   = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] RESET_Q = WIDTH'(RESET_VAL);
  localparam bit               SAT     = (SATURATE == int'(CNT_MODE_SAT));

  logic [WIDTH-1:0] q, q_nxt, ld_val;
  logic             evt, evt_nxt;
  logic [WIDTH:0]   inc, dec;
  logic             at_max, at_min, at_limit;

  // One extra bit lets MODULUS = 2**WIDTH be detected without overflow.
  assign inc      = {1'b0, q} + 1'b1;
  assign dec      = {1'b0, q} - 1'b1;
  assign at_max   = (inc == MOD_X);
  assign at_min   = dec[WIDTH];
  assign at_limit = bus.UP ? at_max : at_min;
  assign ld_val   = WIDTH'(cnt_clamp(33'(bus.D_IN), 33'(MODULUS)));

  // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
  always_comb begin
    q_nxt   = q;
    evt_nxt = 1'b0;
    if (bus.LD) begin
      q_nxt = ld_val;
    end else if (bus.EN) begin
      evt_nxt = at_limit;
      if (!at_limit) begin
        q_nxt = bus.UP ? inc[WIDTH-1:0] : dec[WIDTH-1:0];
      end else if (!SAT) begin
        q_nxt = bus.UP ? '0 : MAX_Q;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      q   <= RESET_Q;
      evt <= 1'b0;
    end else begin
      q   <= q_nxt;
      evt <= evt_nxt;
    end
  end

  assign bus.Q_OUT   = q;
  assign bus.EVT_OUT = evt;
  assign bus.TC_OUT  = bus.EN & CLR_N & ~bus.LD & at_limit;

endmodule

// File: tb/tb_counter_mod_updown.sv
// Self-checking bench for counter_mod_updown: table vectors, corner sequences,
// a two-digit cascade and randomized stimulus against an arithmetic reference model.
module tb_counter_mod_updown;

  logic clk;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instances 0: MOD10 wrap, 1: MOD10 saturate, 2: MOD16 wrap with RESET_VAL=3.
  logic       clr [3];
  logic       en  [3];
  logic       up  [3];
  logic       ld  [3];
  logic [3:0] d   [3];
  logic [3:0] q   [3];
  logic       tc  [3];
  logic       evt [3];

  counter_mod_updown_if #(.WIDTH(4)) bw ();
  counter_mod_updown_if #(.WIDTH(4)) bs ();
  counter_mod_updown_if #(.WIDTH(4)) bm ();

  assign bw.EN = en[0]; assign bw.UP = up[0]; assign bw.LD = ld[0]; assign bw.D_IN = d[0];
  assign bs.EN = en[1]; assign bs.UP = up[1]; assign bs.LD = ld[1]; assign bs.D_IN = d[1];
  assign bm.EN = en[2]; assign bm.UP = up[2]; assign bm.LD = ld[2]; assign bm.D_IN = d[2];
  assign q[0] = bw.Q_OUT; assign tc[0] = bw.TC_OUT; assign evt[0] = bw.EVT_OUT;
  assign q[1] = bs.Q_OUT; assign tc[1] = bs.TC_OUT; assign evt[1] = bs.EVT_OUT;
  assign q[2] = bm.Q_OUT; assign tc[2] = bm.TC_OUT; assign evt[2] = bm.EVT_OUT;

  counter_mod_updown #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .RESET_VAL(0))
    u_wrap (.CLK(clk), .CLR_N(clr[0]), .bus(bw.slave));
  counter_mod_updown #(.WIDTH(4), .MODULUS(10), .SATURATE(1), .RESET_VAL(0))
    u_sat  (.CLK(clk), .CLR_N(clr[1]), .bus(bs.slave));
  counter_mod_updown #(.WIDTH(4), .MODULUS(16), .SATURATE(0), .RESET_VAL(3))
    u_m16  (.CLK(clk), .CLR_N(clr[2]), .bus(bm.slave));

  // Two-digit decimal cascade: stage 1 is enabled by stage 0's terminal count.
  logic clr_c, en_c0;
  counter_mod_updown_if #(.WIDTH(4)) bc0 ();
  counter_mod_updown_if #(.WIDTH(4)) bc1 ();
  assign bc0.EN = en_c0;      assign bc0.UP = 1'b1; assign bc0.LD = 1'b0; assign bc0.D_IN = 4'd0;
  assign bc1.EN = bc0.TC_OUT; assign bc1.UP = 1'b1; assign bc1.LD = 1'b0; assign bc1.D_IN = 4'd0;

  counter_mod_updown #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .RESET_VAL(0))
    u_c0 (.CLK(clk), .CLR_N(clr_c), .bus(bc0.slave));
  counter_mod_updown #(.WIDTH(4), .MODULUS(10), .SATURATE(0), .RESET_VAL(0))
    u_c1 (.CLK(clk), .CLR_N(clr_c), .bus(bc1.slave));

  int n_total = 0;
  int n_pass  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Reference model: counts as plain integers in 0..m-1.
  int mq     [3];
  bit mevt   [3];
  bit mvalid [3] = '{1'b0, 1'b0, 1'b0};

  function automatic int mod_of(input int i);
    return (i == 2) ? 16 : 10;
  endfunction
  function automatic bit sat_of(input int i);
    return (i == 1);
  endfunction
  function automatic int rv_of(input int i);
    return (i == 2) ? 3 : 0;
  endfunction

  function automatic bit model_tc(input int i);
    int m;
    m = mod_of(i);
    return en[i] && clr[i] && !ld[i] && (up[i] ? (mq[i] == m - 1) : (mq[i] == 0));
  endfunction

  function automatic void model_edge(input int i);
    int m, nxt;
    m = mod_of(i);
    if (!clr[i]) begin
      mq[i] = rv_of(i); mevt[i] = 1'b0; mvalid[i] = 1'b1;
    end else if (ld[i]) begin
      mq[i] = (int'(d[i]) < m) ? int'(d[i]) : m - 1; mevt[i] = 1'b0;
    end else if (en[i]) begin
      nxt     = up[i] ? mq[i] + 1 : mq[i] - 1;
      mevt[i] = (nxt < 0) || (nxt >= m);
      if (!mevt[i])        mq[i] = nxt;
      else if (!sat_of(i)) mq[i] = (nxt + m) % m;
    end else begin
      mevt[i] = 1'b0;
    end
  endfunction

  task automatic drive(input int i, input bit c, input bit e, input bit u, input bit l, input int dv);
    clr[i] = c; en[i] = e; up[i] = u; ld[i] = l; d[i] = 4'(dv);
  endtask

  task automatic idle(input int i);
    drive(i, 1'b1, 1'b0, 1'b1, 1'b0, 0);
  endtask

  // One clock: check TC before the edge, advance the model, check Q/EVT after it.
  task automatic step();
    #1;
    for (int i = 0; i < 3; i++) begin
      if (mvalid[i]) check($sformatf("model_tc[%0d]", i), tc[i], model_tc(i));
      model_edge(i);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      if (mvalid[i]) begin
        check($sformatf("model_q[%0d]", i), q[i], mq[i]);
        check($sformatf("model_evt[%0d]", i), evt[i], mevt[i]);
      end
    end
  endtask

  typedef struct {
    int clr, en, up, ld, d;
    int q, evt, tc;
  } vec_t;

  vec_t tbl [18];

  initial begin
    tbl[0] = '{0, 1, 1, 1, 7, 0, 0, 0};
    for (int k = 1; k <= 10; k++) tbl[k] = '{1, 1, 1, 0, 0, k % 10, int'(k == 10), int'(k == 10)};
    tbl[11] = '{1, 0, 1, 0, 0,  0, 0, 0};
    tbl[12] = '{1, 0, 1, 1, 13, 9, 0, 0};
    tbl[13] = '{1, 1, 1, 1, 4,  4, 0, 0};
    tbl[14] = '{1, 1, 1, 1, 9,  9, 0, 0};
    tbl[15] = '{1, 1, 1, 0, 0,  0, 1, 1};
    tbl[16] = '{1, 1, 0, 0, 0,  9, 1, 1};
    tbl[17] = '{1, 0, 0, 0, 0,  9, 0, 0};

    // Power-up reset of everything.
    for (int i = 0; i < 3; i++) drive(i, 1'b0, 1'b0, 1'b1, 1'b0, 0);
    clr_c = 1'b0; en_c0 = 1'b0;
    step();
    check("cascade_reset", {bc1.Q_OUT, bc0.Q_OUT}, 0);
    clr_c = 1'b1;
    for (int i = 0; i < 3; i++) idle(i);

    // Table vectors on the MOD10 wrap counter.
    for (int k = 0; k < 18; k++) begin
      drive(0, tbl[k].clr[0], tbl[k].en[0], tbl[k].up[0], tbl[k].ld[0], tbl[k].d);
      #1 check($sformatf("tbl%0d_tc", k), tc[0], tbl[k].tc);
      step();
      check($sformatf("tbl%0d_q", k), q[0], tbl[k].q);
      check($sformatf("tbl%0d_evt", k), evt[0], tbl[k].evt);
    end
    idle(0);

    // Saturate: pin at 9, pulse repeats while enabled, drops when EN falls.
    drive(1, 1'b1, 1'b0, 1'b1, 1'b1, 8); step();
    check("sat_load8", q[1], 8);
    drive(1, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    step(); check("sat_up1_q", q[1], 9); check("sat_up1_evt", evt[1], 0);
    step(); check("sat_up2_q", q[1], 9); check("sat_up2_evt", evt[1], 1);
    step(); check("sat_up3_q", q[1], 9); check("sat_up3_evt", evt[1], 1);
    drive(1, 1'b1, 1'b0, 1'b1, 1'b0, 0);
    step(); check("sat_hold_q", q[1], 9); check("sat_hold_evt", evt[1], 0);
    drive(1, 1'b1, 1'b0, 1'b0, 1'b1, 0); step();
    drive(1, 1'b1, 1'b1, 1'b0, 1'b0, 0);
    #1 check("sat_down0_tc", tc[1], 1);
    step(); check("sat_down0_q", q[1], 0); check("sat_down0_evt", evt[1], 1);
    drive(1, 1'b1, 1'b0, 1'b1, 1'b1, 13); step();
    check("sat_clamp13", q[1], 9);
    idle(1);

    // Full-range modulus wraps cleanly; mid-count reset beats EN.
    drive(2, 1'b1, 1'b0, 1'b1, 1'b1, 15); step();
    check("m16_load15", q[2], 15);
    drive(2, 1'b1, 1'b1, 1'b1, 1'b0, 0);
    #1 check("m16_tc15", tc[2], 1);
    step(); check("m16_wrap_q", q[2], 0); check("m16_wrap_evt", evt[2], 1);
    drive(2, 1'b1, 1'b0, 1'b1, 1'b1, 5); step();
    check("m16_load5", q[2], 5);
    drive(2, 1'b0, 1'b1, 1'b1, 1'b0, 0);
    #1 check("m16_clr_tc", tc[2], 0);
    step(); check("m16_clr_q", q[2], 3); check("m16_clr_evt", evt[2], 0);
    idle(2);

    // Cascade counts 00..99 then 00, tens digit stepping on the units wrap edge.
    en_c0 = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      step();
      check($sformatf("cascade_%0d", k), 10 * int'(bc1.Q_OUT) + int'(bc0.Q_OUT), k % 100);
    end
    en_c0 = 1'b0;

    // Randomized stimulus on all three configurations.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < 3; i++) begin
        drive(i, $urandom_range(0, 31) != 0, $urandom_range(0, 3) != 0,
              $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
              int'($urandom_range(0, 15)));
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
